// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   - fetch_state_t : fetch controller states
//   - SEL_PC_*      : PC source select codes driven to the PC stage
//   - MEM_LAT_MIN/MAX, CNT_W : supported imem latency range and counter width
//   - lat_preload() : latency counter start value for a given imem latency
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ISSUE,
        WAIT,
        HOLD
    } fetch_state_t;

    localparam logic [1:0] SEL_PC_INC   = 2'b00;
    localparam logic [1:0] SEL_PC_START = 2'b01;
    localparam logic [1:0] SEL_PC_DP    = 2'b11;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    // Counter holds MEM_LAT-1 down to 0, so 2 bits cover the full range.
    localparam int CNT_W = 2;

    // Out-of-range latencies are clamped so the counter can never wrap.
    function automatic logic [CNT_W-1:0] lat_preload(input int lat);
        int l;
        if (lat < MEM_LAT_MIN)
            l = MEM_LAT_MIN;
        else if (lat > MEM_LAT_MAX)
            l = MEM_LAT_MAX;
        else
            l = lat;
        return CNT_W'(l - 1);
    endfunction

endpackage

// File: rtl/fetch_outbuf.sv
// ---------------------------------------------------------------------------
// fetch_outbuf
// Output register toward decode plus a one-entry pending buffer used when a
// memory response arrives while the output slot is still occupied.
//
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   flush        drop both the output entry and the pending entry
//   ready        decode ready (instr_ready)
//   wr_en        a memory response is to be stored this cycle
//   wr_data      response data
//   wr_pc        address of the response
//   instr        instruction presented to decode
//   instr_pc     address of instr
//   instr_valid  instr holds a valid instruction
//   slot_free    output register is empty or is being transferred this cycle
// ---------------------------------------------------------------------------
module fetch_outbuf
    import fetch_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          ready,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] wr_pc,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    output logic          slot_free
);

    logic [DW-1:0] pend_data;
    logic [AW-1:0] pend_pc;
    logic          pend_valid;
    logic          xfer;

    // A ready seen during a flush is not a transfer.
    assign xfer      = instr_valid & ready & ~flush;
    assign slot_free = ~instr_valid | xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            pend_data   <= '0;
            pend_pc     <= '0;
            pend_valid  <= 1'b0;
        end else if (flush) begin
            instr_valid <= 1'b0;
            pend_valid  <= 1'b0;
        end else if (wr_en) begin
            // The controller never reads while an entry is pending, so a
            // new response cannot collide with pend_valid.
            if (slot_free) begin
                instr       <= wr_data;
                instr_pc    <= wr_pc;
                instr_valid <= 1'b1;
            end else begin
                pend_data  <= wr_data;
                pend_pc    <= wr_pc;
                pend_valid <= 1'b1;
            end
        end else if (pend_valid && slot_free) begin
            instr       <= pend_data;
            instr_pc    <= pend_pc;
            instr_valid <= 1'b1;
            pend_valid  <= 1'b0;
        end else if (xfer) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage between the PC stage and decode. Issues one read at
// a time to a fixed-latency synchronous imem, returns each word with its
// address over a valid/ready handshake, and steers the PC stage through
// load_pc/sel_pc for start, sequential increment and datapath redirect.
//
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   start        pulse: begin fetching from start_pc (PC stage loads it)
//   halt         level: stop issuing new requests
//   redirect     pulse: datapath branch, PC stage loads dp_pc
//   pc_in        current PC from the PC stage
//   load_pc      PC load enable
//   sel_pc       PC source: 00 increment, 01 start_pc, 11 dp_pc
//   imem_rd_en   memory read strobe
//   imem_addr    memory address
//   imem_rdata   read data, valid MEM_LAT cycles after the strobe
//   instr        instruction to decode
//   instr_pc     address of instr
//   instr_valid  instr is valid
//   instr_ready  decode accepts (transfer when valid & ready & !redirect)
//   busy         controller not idle
// ---------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 11,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          halt,
    input  logic          redirect,
    input  logic [AW-1:0] pc_in,
    output logic          load_pc,
    output logic [1:0]    sel_pc,
    output logic          imem_rd_en,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic          busy
);

    fetch_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             discard;
    logic [AW-1:0]    req_pc;

    logic flush;
    logic arrive;
    logic buf_wr;
    logic slot_free;

    // Redirect is meaningless while idle, so it only flushes when running.
    assign flush  = redirect & (state != IDLE);
    assign arrive = (state == WAIT) && (cnt == '0);
    // A response arriving in the same cycle as a redirect is already stale.
    assign buf_wr = arrive & ~discard & ~redirect;
    assign busy   = (state != IDLE);

    // PC-stage control and read strobe are decoded from the current state and
    // this cycle's redirect/halt so a branch takes effect without a bubble.
    always_comb begin
        load_pc    = 1'b0;
        sel_pc     = SEL_PC_INC;
        imem_rd_en = 1'b0;
        imem_addr  = '0;
        case (state)
            INIT: begin
                load_pc = 1'b1;
                sel_pc  = SEL_PC_START;
            end
            ISSUE: begin
                if (redirect) begin
                    load_pc = 1'b1;
                    sel_pc  = SEL_PC_DP;
                end else if (!halt) begin
                    imem_rd_en = 1'b1;
                    imem_addr  = pc_in;
                    load_pc    = 1'b1;
                    sel_pc     = SEL_PC_INC;
                end
            end
            WAIT, HOLD: begin
                if (redirect) begin
                    load_pc = 1'b1;
                    sel_pc  = SEL_PC_DP;
                end
            end
            default: begin
                load_pc = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            discard <= 1'b0;
            req_pc  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        state <= INIT;
                end
                INIT: begin
                    state <= ISSUE;
                end
                ISSUE: begin
                    // Redirect wins over halt: the PC load happens now and
                    // halt is seen again on the next ISSUE cycle.
                    if (redirect) begin
                        state <= ISSUE;
                    end else if (halt) begin
                        state <= IDLE;
                    end else begin
                        req_pc <= pc_in;
                        cnt    <= lat_preload(MEM_LAT);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                        if (redirect)
                            discard <= 1'b1;
                    end else begin
                        discard <= 1'b0;
                        if (discard || redirect)
                            state <= ISSUE;
                        else if (slot_free)
                            state <= ISSUE;
                        else
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    // The output buffer moves the pending entry on its own
                    // once the slot frees; a redirect drops it.
                    if (redirect || slot_free)
                        state <= ISSUE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    fetch_outbuf #(
        .AW(AW),
        .DW(DW)
    ) u_outbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .ready      (instr_ready),
        .wr_en      (buf_wr),
        .wr_data    (imem_rdata),
        .wr_pc      (req_pc),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .slot_free  (slot_free)
    );

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly downstream of the program counter. It consumes the PC value and drives that counter's load_pc/sel_pc controls.
- Issues reads to a fixed-latency synchronous instruction memory and returns each instruction word with its address.
- Presents instructions to decode over a valid/ready handshake. Handles start, datapath redirect (branch) flush, and halt.
- One request outstanding at a time, plus a one-entry pending buffer for backpressure.

Parameters:
- MEM_LAT, 1, imem read latency in cycles; legal range 1..4.
- AW, 11, address / PC width.
- DW, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin fetching from start_pc (PC stage loads it)
- halt  in  1  level; stop issuing new requests
- redirect  in  1  pulse; datapath branch; PC stage loads dp_pc
- pc_in  in  AW  current PC from PC stage
- load_pc  out  1  PC load enable
- sel_pc  out  2  PC source select: 00 increment, 01 start_pc, 11 dp_pc
- imem_rd_en  out  1  memory read strobe
- imem_addr  out  AW  memory address
- imem_rdata  in  DW  read data, valid exactly MEM_LAT cycles after the strobe cycle
- instr  out  DW  instruction to decode
- instr_pc  out  AW  address of instr
- instr_valid  out  1  output holds a valid instruction
- instr_ready  in  1  decode accepts; transfer when instr_valid & instr_ready & !redirect
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0) sets: state IDLE; instr, instr_pc, pending regs, cnt and discard flag = 0; instr_valid=0. Combinational outputs resolve to load_pc=0, sel_pc=00, imem_rd_en=0, busy=0.
- States: IDLE, INIT, ISSUE, WAIT, HOLD.
- IDLE: outputs inactive. start -> INIT. redirect ignored.
- INIT: load_pc=1, sel_pc=01 -> ISSUE. pc_in is valid from ISSUE onward.
- ISSUE:
  - halt=1: go to IDLE, no read.
  - redirect=1: load_pc=1, sel_pc=11, no read, stay in ISSUE.
  - Otherwise: imem_rd_en=1, imem_addr=pc_in, latch req_pc=pc_in, load_pc=1, sel_pc=00, cnt<=MEM_LAT-1 -> WAIT.
- WAIT:
  - cnt!=0: decrement.
  - cnt==0 (arrival cycle):
    - discard set: drop data, clear discard -> ISSUE.
    - Output slot free (!instr_valid or transfer this cycle): instr<=imem_rdata, instr_pc<=req_pc, instr_valid<=1 -> ISSUE.
    - Slot occupied: pend<=imem_rdata, pend_pc<=req_pc -> HOLD.
- HOLD: when the slot frees, move pend into the output (instr_valid<=1) -> ISSUE.
- Redirect in WAIT or HOLD:
  - load_pc=1, sel_pc=11 (overrides increment).
  - WAIT: discard<=1; the in-flight response is dropped at arrival.
  - HOLD: pending entry dropped -> ISSUE.
- Redirect in any non-IDLE state clears instr_valid at the next edge. A concurrent instr_ready is not a transfer; decode must also ignore it.
- redirect and halt together: redirect's PC load is performed; halt is honoured at the next ISSUE.
- start outside IDLE is ignored.
- Throughput: one instruction per MEM_LAT+1 cycles with no backpressure.
- instr/instr_pc are stable while instr_valid & !instr_ready.
- PC arithmetic is performed in the PC stage; the 11-bit address wrap (0x7FF -> 0x000) passes through unmodified.
- Reset mid-operation aborts any request. Late imem data is never captured because the state is IDLE.
- halt asserted while in WAIT/HOLD: the current request completes and is delivered, then the block goes to IDLE at the ISSUE decision.

Decomposition:
- fetch_pkg holds:
  - state enum fetch_state_t {IDLE, INIT, ISSUE, WAIT, HOLD}
  - constants SEL_PC_INC=2'b00, SEL_PC_START=2'b01, SEL_PC_DP=2'b11
  - MEM_LAT range limits
- One sub-module, fetch_outbuf, contains:
  - output register plus pending entry and valid bits
  - slot-free logic
  - flush input
- FSM, latency counter and PC-control decode stay in instr_fetch.

Test Plan:
- Start, MEM_LAT=1, start_pc=0x010, imem[a]=0xE000_0000+a, instr_ready=1 -> instrs 0xE000_0010, 0xE000_0011, 0xE000_0012 with instr_pc 0x010..0x012, one every 2 cycles; first load_pc/sel_pc=01 in the cycle after start.
- Backpressure, MEM_LAT=2, instr_ready=0 for 10 cycles after first valid -> instr stays 0x…10, pending holds 0x…11, no further imem_rd_en until ready=1; then 0x…11 delivered the cycle after the transfer.
- Redirect in WAIT, MEM_LAT=3, redirect with dp_pc=0x200 one cycle after issue of 0x014 -> sel_pc=11 that cycle, response for 0x014 dropped, next instr_pc=0x200, no valid instr between.
- Redirect with instr_valid=1 and instr_ready=1 same cycle -> instr_valid=0 next cycle, next delivered instr_pc=dp_pc.
- halt during WAIT -> current instr delivered, state IDLE, no imem_rd_en afterwards; start again -> restarts at start_pc.
- rst_n low mid-WAIT, released 2 cycles later -> all outputs 0, state IDLE, late imem_rdata not captured; wrap case start_pc=0x7FF -> next instr_pc=0x000.
